et_sng_ctrl: RTL and testbench

//  Early-terminating stochastic number generator, directly downstream of the

---
 rtl/sc_et_pkg.sv | 40 ++++
 rtl/masked_counter.sv | 28 ++
 rtl/et_sng_ctrl.sv | 121 ++++++++++++
 tb/tb_et_sng_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sc_et_pkg.sv
// Shared types and helpers for the early-terminating SNG.
// Helpers work on 32-bit values; callers pass the live width.
package sc_et_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic [31:0] bitrev(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < w) r[w-1-i] = v[i];
    return r;
  endfunction

  // Ones outside the mask force the carry to skip them.
  function automatic logic [31:0] masked_inc(
    input logic [31:0] v,
    input logic [31:0] m
  );
    return ((v | ~m) + 32'd1) & m;
  endfunction

  function automatic int popcount(
    input logic [31:0] v
  );
    int c;
    c = 0;
    for (int i = 0; i < 32; i++)
      c += int'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/masked_counter.sv
// Counter that only advances through the bits set in mask.
// Bits outside the mask stay zero.
module masked_counter
  import sc_et_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] mask,
  output logic [W-1:0] value
);

  logic [31:0] nxt;
  logic        unused_hi;

  assign nxt = masked_inc(32'(value), 32'(mask));
  assign unused_hi = ^nxt;

  always_ff @(posedge clk) begin
    if (!rst_n)   value <= '0;
    else if (clr) value <= '0;
    else if (en)  value <= nxt[W-1:0];
  end

endmodule

// File: rtl/et_sng_ctrl.sv
// Early-terminating comparator SNG: runs 2^P cycles, P being
// the widest active mask, and reports per-stream ones counts.
module et_sng_ctrl
  import sc_et_pkg::*;
#(
  parameter int W        = 4,
  parameter int N        = 2,
  parameter int S_GROUPS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [N-1:0][W-1:0]        Bxs,
  input  logic [S_GROUPS-1:0][W-1:0] S,
  input  logic [W-1:0]               k_init,
  output logic                       busy,
  output logic                       bs_valid,
  output logic [N-1:0]               bs,
  output logic                       done,
  output logic [N-1:0][W:0]          ones_cnt,
  output logic [W:0]                 run_len,
  output logic [W-1:0]               k_out
);

  state_t state, nxt;

  logic [N-1:0][W-1:0]        bx_lat;
  logic [S_GROUPS-1:0][W-1:0] s_lat;
  logic [W-1:0]               k_lat;
  logic [S_GROUPS-1:0][W-1:0] mc;
  logic [W:0]                 cnt;
  logic [W:0]                 len;
  logic [N-1:0][W:0]          ones;
  logic                       accept;
  logic                       run;
  logic                       last;
  int                         p_max;

  assign accept = (state == IDLE) && start;
  assign run    = (state == RUN);
  assign last   = run && (cnt == len - (W+1)'(1));

  for (genvar g = 0; g < S_GROUPS; g++) begin : g_mc
    masked_counter #(.W(W)) u_mc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .en    (run),
      .mask  (s_lat[g]),
      .value (mc[g])
    );
  end

  always_comb begin
    p_max = 0;
    for (int g = 0; g < S_GROUPS; g++)
      if (popcount(32'(s_lat[g])) > p_max)
        p_max = popcount(32'(s_lat[g]));
    len = (W+1)'(1) << p_max;
  end

  for (genvar j = 0; j < N; j++) begin : g_cmp
    logic [31:0] r;
    logic        unused_r;
    assign r = bitrev(32'(mc[j % S_GROUPS]), W);
    assign unused_r = ^r;
    assign bs[j] = run && (bx_lat[j] > r[W-1:0]);
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (last)  nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bx_lat   <= '0;
      s_lat    <= '0;
      k_lat    <= '0;
      cnt      <= '0;
      ones     <= '0;
      ones_cnt <= '0;
      run_len  <= '0;
      k_out    <= '0;
    end else begin
      if (accept) begin
        bx_lat <= Bxs;
        s_lat  <= S;
        k_lat  <= k_init;
        cnt    <= '0;
        ones   <= '0;
      end
      if (run) begin
        cnt <= cnt + (W+1)'(1);
        for (int j = 0; j < N; j++)
          ones[j] <= ones[j] + (W+1)'(bs[j]);
      end
      if (last) begin
        for (int j = 0; j < N; j++)
          ones_cnt[j] <= ones[j] + (W+1)'(bs[j]);
        run_len <= len;
        k_out   <= k_lat;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign bs_valid = run;
  assign done     = (state == DONE);

endmodule

// File: tb/tb_et_sng_ctrl.sv
// Bench for et_sng_ctrl: vector table, per-bit scoreboard,
// abort/ignore sequences, and a single-group instance.
module tb_et_sng_ctrl;

  logic clk = 0;
  logic rst_n;
  logic start_v;
  logic sel;
  logic [1:0][3:0] bx;
  logic [1:0][3:0] s;
  logic [3:0] k;

  logic            busy0, busy1, bsv0, bsv1, dn0, dn1;
  logic [1:0]      bs0, bs1;
  logic [1:0][4:0] oc0, oc1;
  logic [4:0]      rl0, rl1;
  logic [3:0]      ko0, ko1;
  logic [0:0][3:0] s_one;

  logic            m_busy, m_bsv, m_done;
  logic [1:0]      m_bs;
  logic [1:0][4:0] m_oc;
  logic [4:0]      m_rl;
  logic [3:0]      m_ko;

  always #5 clk = ~clk;

  assign s_one[0] = s[0];

  et_sng_ctrl #(.W(4), .N(2), .S_GROUPS(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_v & ~sel),
    .Bxs(bx), .S(s), .k_init(k),
    .busy(busy0), .bs_valid(bsv0), .bs(bs0), .done(dn0),
    .ones_cnt(oc0), .run_len(rl0), .k_out(ko0)
  );

  et_sng_ctrl #(.W(4), .N(2), .S_GROUPS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v & sel),
    .Bxs(bx), .S(s_one), .k_init(k),
    .busy(busy1), .bs_valid(bsv1), .bs(bs1), .done(dn1),
    .ones_cnt(oc1), .run_len(rl1), .k_out(ko1)
  );

  assign m_busy = sel ? busy1 : busy0;
  assign m_bsv  = sel ? bsv1  : bsv0;
  assign m_done = sel ? dn1   : dn0;
  assign m_bs   = sel ? bs1   : bs0;
  assign m_oc   = sel ? oc1   : oc0;
  assign m_rl   = sel ? rl1   : rl0;
  assign m_ko   = sel ? ko1   : ko0;

  typedef struct {
    logic [3:0] b0, b1, s0, s1, k;
    int sg;
    int o0, o1, len;
  } vec_t;

  vec_t vt[6];
  logic [1:0] q[$];
  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int pc4(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  // Scatter the low bits of i onto the set bits of m.
  function automatic logic [3:0] dep(input int i, input logic [3:0] m);
    logic [3:0] o;
    int b;
    o = '0;
    b = 0;
    for (int p = 0; p < 4; p++)
      if (m[p]) begin
        o[p] = i[b];
        b++;
      end
    return o;
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  task automatic run(input int idx, input int mode);
    vec_t v;
    int L, p, kk;
    bit got;
    logic [1:0] e, a;
    logic [3:0] m, r;
    v = vt[idx];
    p = pc4(v.s0);
    if (v.sg == 2 && pc4(v.s1) > p) p = pc4(v.s1);
    L = 1 << p;
    for (int i = 0; i < L; i++) begin
      for (int j = 0; j < 2; j++) begin
        m = (j == 1 && v.sg == 2) ? v.s1 : v.s0;
        r = rev4(dep(i % (1 << pc4(m)), m));
        e[j] = ((j == 0) ? v.b0 : v.b1) > r;
      end
      q.push_back(e);
    end
    @(negedge clk);
    bx[0] = v.b0; bx[1] = v.b1;
    s[0] = v.s0; s[1] = v.s1;
    k = v.k;
    start_v = 1;
    got = 0;
    for (kk = 0; kk < L + 4; kk++) begin
      @(negedge clk);
      start_v = 0;
      bx = 8'($urandom);
      s = 8'($urandom);
      k = 4'($urandom);
      if (m_bsv) begin
        if (q.size() == 0) chk("bs_extra", 1, 0);
        else begin
          a = q.pop_front();
          chk("bs", int'(m_bs), int'(a));
        end
      end
      if (m_done) begin
        got = 1;
        chk("done_cycle", kk, L);
        chk("ones0", int'(m_oc[0]), v.o0);
        chk("ones1", int'(m_oc[1]), v.o1);
        chk("run_len", int'(m_rl), v.len);
        chk("k_out", int'(m_ko), int'(v.k));
        if (mode == 1) start_v = 1;
        break;
      end
      if (mode == 1 && kk == 1) start_v = 1;
      if (mode == 2 && kk == 2) begin
        rst_n = 0;
        @(negedge clk);
        chk("rst_busy", int'(m_busy), 0);
        chk("rst_bsv", int'(m_bsv), 0);
        chk("rst_bs", int'(m_bs), 0);
        chk("rst_ones", int'(m_oc), 0);
        chk("rst_len", int'(m_rl), 0);
        chk("rst_k", int'(m_ko), 0);
        repeat (3) begin
          @(negedge clk);
          chk("rst_done", int'(m_done), 0);
        end
        rst_n = 1;
        q.delete();
        return;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    @(negedge clk);
    start_v = 0;
    chk("done_pulse", int'(m_done), 0);
    chk("idle_busy", int'(m_busy), 0);
    @(negedge clk);
    chk("idle_busy2", int'(m_busy), 0);
    chk("held_ones0", int'(m_oc[0]), v.o0);
    chk("held_len", int'(m_rl), v.len);
    chk("q_empty", q.size(), 0);
    q.delete();
  endtask

  initial begin
    vt[0] = '{4'h8, 4'h4, 4'h3, 4'h3, 4'h8, 2, 2, 1, 4};
    vt[1] = '{4'h6, 4'h8, 4'hF, 4'h1, 4'h4, 2, 6, 8, 16};
    vt[2] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2, 0, 0, 1};
    vt[3] = '{4'hF, 4'h0, 4'hF, 4'h5, 4'h8, 2, 15, 0, 16};
    vt[4] = '{4'h3, 4'h5, 4'h4, 4'hA, 4'h2, 2, 4, 3, 4};
    vt[5] = '{4'h5, 4'h3, 4'h7, 4'h0, 4'h4, 1, 3, 2, 8};
    sel = 0;
    rst_n = 0;
    start_v = 0;
    bx = '0;
    s = '0;
    k = '0;
    repeat (3) @(negedge clk);
    chk("r_busy", int'(busy0), 0);
    chk("r_bsv", int'(bsv0), 0);
    chk("r_bs", int'(bs0), 0);
    chk("r_done", int'(dn0), 0);
    chk("r_ones", int'(oc0), 0);
    chk("r_len", int'(rl0), 0);
    chk("r_k", int'(ko0), 0);
    rst_n = 1;
    run(0, 0);
    run(0, 1);
    run(1, 2);
    run(1, 0);
    for (int i = 2; i < 5; i++) run(i, 0);
    sel = 1;
    run(5, 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
